// File: rtl/fc_sched_pkg.sv
// Shared types for the fully-connected layer memory scheduler.
// State encoding and default address/tile widths.
package fc_sched_pkg;

  localparam int ADDR_W = 8;
  localparam int TILE_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/fc_tile_counter.sv
// Nested (output tile, input tile) counter for the FC scheduler.
// Exposes current, next and last-step indications.
module fc_tile_counter
  import fc_sched_pkg::*;
#(
  parameter int TILE_BITS = TILE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [TILE_BITS-1:0] n_in_i,
  input  logic [TILE_BITS-1:0] n_out_i,
  output logic [TILE_BITS-1:0] it_o,
  output logic [TILE_BITS-1:0] ot_o,
  output logic [TILE_BITS-1:0] it_nx_o,
  output logic [TILE_BITS-1:0] ot_nx_o,
  output logic                 last_o
);

  logic [TILE_BITS-1:0] n_in_q, n_out_q;
  logic [TILE_BITS-1:0] it_q, ot_q;
  logic                 it_wrap, ot_wrap;

  assign it_wrap = (it_q == n_in_q - 1'b1);
  assign ot_wrap = (ot_q == n_out_q - 1'b1);

  assign it_o    = it_q;
  assign ot_o    = ot_q;
  assign it_nx_o = it_wrap ? '0 : it_q + 1'b1;
  assign ot_nx_o = !it_wrap ? ot_q :
                   ot_wrap  ? '0   : ot_q + 1'b1;
  assign last_o  = it_wrap && ot_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_in_q  <= '0;
      n_out_q <= '0;
      it_q    <= '0;
      ot_q    <= '0;
    end else if (load_i) begin
      n_in_q  <= n_in_i;
      n_out_q <= n_out_i;
      it_q    <= '0;
      ot_q    <= '0;
    end else if (step_i) begin
      it_q <= it_nx_o;
      ot_q <= ot_nx_o;
    end
  end

endmodule

// File: rtl/fc_mem_sched.sv
// Sequencer for the shared ifmap/ofmap buffer feeding the MAC array.
// Walks output tiles outer, input tiles inner; all outputs registered.
module fc_mem_sched
  import fc_sched_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDR_W,
  parameter int COLS_MAC     = 4,
  parameter int INPUTS_MAC   = 6,
  parameter int MAC_LAT      = 2,
  parameter int TILE_BITS    = TILE_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [ADDRESS_BITS-1:0]                  if_base,
  input  logic [ADDRESS_BITS-1:0]                  of_base,
  input  logic [TILE_BITS-1:0]                     n_in_tiles,
  input  logic [TILE_BITS-1:0]                     n_out_tiles,
  output logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] if_address,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]   of_r_address,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]   of_w_address,
  output logic [COLS_MAC-1:0]                      en_w,
  output logic                                     mac_valid,
  output logic                                     acc_first,
  output logic                                     busy,
  output logic                                     done
);

  typedef logic [ADDRESS_BITS-1:0] a_t;
  typedef logic [TILE_BITS-1:0]    t_t;

  function automatic a_t calc(a_t base, t_t t, int stride, int idx);
    logic [31:0] s;
    s = 32'(base) + 32'(t) * 32'(stride) + 32'(idx);
    return s[ADDRESS_BITS-1:0];
  endfunction

  state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  a_t ifb_q, ofb_q, ifb, ofb;

  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] if_q, if_d;
  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]   of_q, of_d;
  logic [COLS_MAC-1:0] en_w_q, en_w_d;
  logic mv_q, mv_d, af_q, af_d;
  logic busy_q, busy_d, done_q, done_d;

  logic load, step, iss, last;
  t_t it, ot, it_nx, ot_nx, iss_it, iss_ot;

  fc_tile_counter #(
    .TILE_BITS(TILE_BITS)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .n_in_i (n_in_tiles),
    .n_out_i(n_out_tiles),
    .it_o   (it),
    .ot_o   (ot),
    .it_nx_o(it_nx),
    .ot_nx_o(ot_nx),
    .last_o (last)
  );

  // Bases come straight from the ports on the launch cycle.
  assign ifb = (state_q == IDLE) ? if_base : ifb_q;
  assign ofb = (state_q == IDLE) ? of_base : ofb_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    load    = 1'b0;
    step    = 1'b0;
    iss     = 1'b0;
    iss_it  = it_nx;
    iss_ot  = ot_nx;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (n_in_tiles == '0 || n_out_tiles == '0) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            iss     = 1'b1;
            iss_it  = '0;
            iss_ot  = '0;
          end
        end
      end
      ISSUE: begin
        if (MAC_LAT == 0) begin
          step = 1'b1;
          if (last) state_d = DONE;
          else begin
            state_d = ISSUE;
            iss     = 1'b1;
          end
        end else if (MAC_LAT == 1) begin
          state_d = WRITE;
        end else begin
          state_d = WAIT;
          wcnt_d  = 4'(MAC_LAT - 2);
        end
      end
      WAIT: begin
        if (wcnt_q == '0) state_d = WRITE;
        else wcnt_d = wcnt_q - 1'b1;
      end
      WRITE: begin
        step = 1'b1;
        if (last) state_d = DONE;
        else begin
          state_d = ISSUE;
          iss     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_d = if_q;
    of_d = of_q;
    if (iss) begin
      for (int i = 0; i < INPUTS_MAC; i++)
        if_d[i] = calc(ifb, iss_it, INPUTS_MAC, i);
      for (int j = 0; j < COLS_MAC; j++)
        of_d[j] = calc(ofb, iss_ot, COLS_MAC, j);
    end
    mv_d   = iss;
    af_d   = iss && (iss_it == '0);
    en_w_d = {COLS_MAC{(state_d == WRITE) || (iss && MAC_LAT == 0)}};
    busy_d = (state_d == ISSUE) || (state_d == WAIT) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ifb_q   <= '0;
      ofb_q   <= '0;
      if_q    <= '0;
      of_q    <= '0;
      en_w_q  <= '0;
      mv_q    <= 1'b0;
      af_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (load) begin
        ifb_q <= if_base;
        ofb_q <= of_base;
      end
      if_q   <= if_d;
      of_q   <= of_d;
      en_w_q <= en_w_d;
      mv_q   <= mv_d;
      af_q   <= af_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign if_address   = if_q;
  assign of_r_address = of_q;
  assign of_w_address = of_q;
  assign en_w         = en_w_q;
  assign mac_valid    = mv_q;
  assign acc_first    = af_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fc_mem_sched.sv
// Directed bench for fc_mem_sched (MAC_LAT=2 main DUT,
// plus a MAC_LAT=0 instance sharing the same stimulus).
module tb_fc_mem_sched;

  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] if_base, of_base, n_in, n_out;

  logic [5:0][7:0] ifa, ifa0;
  logic [3:0][7:0] ofr, ofw, ofr0, ofw0;
  logic [3:0] enw, enw0;
  logic mv, af, busy, done, mv0, af0, busy0, done0;

  int checks = 0;
  int errors = 0;
  int busy_cnt, enw_cnt, mv_cnt, mv0_cnt;

  always #5 clk = ~clk;

  fc_mem_sched #(.MAC_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .if_base(if_base), .of_base(of_base),
    .n_in_tiles(n_in), .n_out_tiles(n_out),
    .if_address(ifa), .of_r_address(ofr), .of_w_address(ofw),
    .en_w(enw), .mac_valid(mv), .acc_first(af),
    .busy(busy), .done(done)
  );

  fc_mem_sched #(.MAC_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .if_base(if_base), .of_base(of_base),
    .n_in_tiles(n_in), .n_out_tiles(n_out),
    .if_address(ifa0), .of_r_address(ofr0), .of_w_address(ofw0),
    .en_w(enw0), .mac_valid(mv0), .acc_first(af0),
    .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (enw != 4'h0) enw_cnt++;
    if (mv) mv_cnt++;
    if (mv0) mv0_cnt++;
    if (!rst && (mv0 || enw0 != 4'h0))
      chk("ml0_enw_eq_mv", 32'(enw0), mv0 ? 32'hF : 32'h0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    busy_cnt = 0; enw_cnt = 0; mv_cnt = 0; mv0_cnt = 0;
  endtask

  task automatic chk_if(input string tag, input int base);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_if%0d", tag, i), 32'(ifa[i]), (base + i) % 256);
  endtask

  task automatic chk_of(input string tag, input int base, input bit w);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_of%0d", tag, j),
          32'(w ? ofw[j] : ofr[j]), (base + j) % 256);
  endtask

  task automatic launch(input int ib, input int ob, input int ni, input int no);
    if_base = 8'(ib); of_base = 8'(ob);
    n_in = 8'(ni); n_out = 8'(no);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk("done_seen", 32'(done), 1);
    tick;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    if_base = '0; of_base = '0; n_in = '0; n_out = '0;
    clr;
    repeat (3) tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mv", 32'(mv), 0);
    chk("rst_enw", 32'(enw), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_if0", 32'(ifa[0]), 0);
    rst = 1'b0;
    tick;

    // Two input tiles, one output tile.
    clr;
    launch(2, 0, 2, 1);
    chk("t1_mv", 32'(mv), 1);
    chk("t1_af", 32'(af), 1);
    chk("t1_enw_iss", 32'(enw), 0);
    chk_if("t1a", 2);
    chk_of("t1a_r", 0, 0);
    tick;
    chk("t1_wait_mv", 32'(mv), 0);
    chk("t1_wait_busy", 32'(busy), 1);
    chk("t1_wait_enw", 32'(enw), 0);
    tick;
    chk("t1_wr_enw", 32'(enw), 32'hF);
    chk_of("t1a_w", 0, 1);
    tick;
    chk("t1_mv2", 32'(mv), 1);
    chk("t1_af2", 32'(af), 0);
    chk_if("t1b", 8);
    tick;
    tick;
    chk("t1_wr2_enw", 32'(enw), 32'hF);
    tick;
    chk("t1_done", 32'(done), 1);
    chk("t1_done_busy", 32'(busy), 0);
    tick;
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_busy_cnt", 32'(busy_cnt), 6);
    chk("t1_ml0_mv_cnt", 32'(mv0_cnt), 2);

    // One input tile, two output tiles.
    clr;
    launch(0, 4, 1, 2);
    chk("t2_af", 32'(af), 1);
    chk_of("t2a_r", 4, 0);
    tick;
    tick;
    chk_of("t2a_w", 4, 1);
    tick;
    chk("t2_af2", 32'(af), 1);
    chk_of("t2b_r", 8, 0);
    chk_if("t2b", 0);
    wait_done;
    chk("t2_enw_cnt", 32'(enw_cnt), 2);

    // Zero output tiles: straight to done.
    clr;
    launch(0, 0, 3, 0);
    chk("t3_done", 32'(done), 1);
    chk("t3_busy", 32'(busy), 0);
    tick;
    chk("t3_done_pulse", 32'(done), 0);
    chk("t3_mv_cnt", 32'(mv_cnt), 0);
    chk("t3_enw_cnt", 32'(enw_cnt), 0);
    chk("t3_busy_cnt", 32'(busy_cnt), 0);

    // Address wrap.
    launch(252, 254, 1, 1);
    chk_if("t4", 252);
    chk_of("t4_r", 254, 0);
    wait_done;

    // Reset mid-layer, then relaunch.
    launch(2, 0, 2, 2);
    tick;
    chk("t5_in_wait", 32'(busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_mv", 32'(mv), 0);
    chk("t5_rst_enw", 32'(enw), 0);
    chk("t5_rst_if0", 32'(ifa[0]), 0);
    chk("t5_rst_ofw3", 32'(ofw[3]), 0);
    tick;
    chk("t5_idle", 32'(busy), 0);
    launch(10, 0, 2, 2);
    chk("t5_af", 32'(af), 1);
    chk_if("t5", 10);
    chk_of("t5_r", 0, 0);
    wait_done;

    // Start while busy is ignored.
    clr;
    launch(20, 40, 1, 1);
    if_base = 8'd100; of_base = 8'd7; n_in = 8'd5; n_out = 8'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("t6_enw", 32'(enw), 32'hF);
    chk_of("t6_w", 40, 1);
    tick;
    chk("t6_done", 32'(done), 1);
    tick;
    tick;
    chk("t6_busy_cnt", 32'(busy_cnt), 3);
    chk("t6_hold_if0", 32'(ifa[0]), 20);
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
